// File: rtl/mmu_tile_dispatcher.sv
// Tile dispatcher: accepts an N-tile job and issues one start pulse per tile, waiting for
// each done pulse. Optional WAIT watchdog enabled by defining MMU_DISPATCH_TIMEOUT_EN.
module mmu_tile_dispatcher #(
  parameter int TILE_CNT_W = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  input  logic [TILE_CNT_W-1:0] cmd_tiles_i,
  output logic                  cmd_ready_o,
  output logic                  start_o,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic [TILE_CNT_W-1:0] tiles_done_o,
  output logic                  job_done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [TILE_CNT_W-1:0] tgt_q, tgt_d;
  logic [TILE_CNT_W-1:0] tiles_q, tiles_d;

`ifdef MMU_DISPATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      tiles_q <= '0;
`ifdef MMU_DISPATCH_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tiles_q <= tiles_d;
`ifdef MMU_DISPATCH_TIMEOUT_EN
      timer_q <= timer_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    tiles_d = tiles_q;
`ifdef MMU_DISPATCH_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          tgt_d   = cmd_tiles_i;
          tiles_d = '0;
`ifdef MMU_DISPATCH_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = (cmd_tiles_i == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MMU_DISPATCH_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the last allowed cycle takes priority over the abort.
        if (done_i) begin
          tiles_d = tiles_q + 1'b1;
          state_d = (tiles_d == tgt_q) ? S_FIN : S_ISSUE;
        end
`ifdef MMU_DISPATCH_TIMEOUT_EN
        else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = (state_q == S_IDLE);
    start_o      = (state_q == S_ISSUE);
    busy_o       = (state_q != S_IDLE);
    job_done_o   = (state_q == S_FIN);
    tiles_done_o = tiles_q;
`ifdef MMU_DISPATCH_TIMEOUT_EN
    err_o        = err_q;
`else
    err_o        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mmu_tile_dispatcher.sv
// Scoreboard bench for mmu_tile_dispatcher: a run-counter model returns done_i five cycles
// after each start_o; expected start/job_done events are derived from job timing arithmetic.
module tb_mmu_tile_dispatcher;
  localparam int TW   = 8;
  localparam int TO   = 16;
  localparam int STEP = 6;   // start-to-start spacing: 5-cycle run plus one reissue cycle

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [TW-1:0] cmd_tiles = '0;
  logic          done = 1'b0;
  logic          cmd_ready_o, start_o, busy_o, job_done_o, err_o;
  logic [TW-1:0] tiles_done_o;

  mmu_tile_dispatcher #(.TILE_CNT_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_tiles_i(cmd_tiles),
    .cmd_ready_o(cmd_ready_o), .start_o(start_o), .done_i(done), .busy_o(busy_o),
    .tiles_done_o(tiles_done_o), .job_done_o(job_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_done; int cycle; int tiles; bit err;} ev_t;
  ev_t expq[$];

  int checks = 0, errors = 0;
  int free_cyc = 0, exp_tiles = 0;
  bit exp_err = 1'b0;
  bit mute = 1'b0, spur_idle = 1'b0, spur_issue = 1'b0;
  int rc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run-counter model plus spurious done injection in IDLE / ISSUE.
  always @(negedge clk) begin
    if (rst) begin
      rc   = 0;
      done = 1'b0;
    end else if (start_o) begin
      rc   = mute ? 0 : 5;
      done = spur_issue;
    end else if (rc != 0) begin
      rc   = rc - 1;
      done = (rc == 0);
    end else begin
      done = cmd_ready_o && spur_idle && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: every start_o / job_done_o must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (start_o || job_done_o)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: start=%0b job_done=%0b at cycle %0d, expected none",
                 start_o, job_done_o, cyc);
      end else begin
        ev_t e;
        e = expq.pop_front();
        chk("event_kind", int'(job_done_o), int'(e.is_done));
        chk("event_start", int'(start_o), int'(!e.is_done));
        chk("event_cycle", cyc, e.cycle);
        chk("event_tiles_done", int'(tiles_done_o), e.tiles);
        chk("event_err", int'(err_o), int'(e.err));
        chk("event_busy", int'(busy_o), 1);
        chk("event_cmd_ready", int'(cmd_ready_o), 0);
      end
    end
  end

  task automatic check_idle();
    chk("idle_cmd_ready", int'(cmd_ready_o), 1);
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_start", int'(start_o), 0);
    chk("idle_job_done", int'(job_done_o), 0);
    chk("idle_tiles_done", int'(tiles_done_o), exp_tiles);
    chk("idle_err", int'(err_o), int'(exp_err));
  endtask

  task automatic wait_free();
    int g = 0;
    while (cyc < free_cyc && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < free_cyc) chk("wait_free_bound", cyc, free_cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a job; the accept cycle comes from the model's idea of when the dispatcher frees up.
  task automatic issue(input int n);
    int acc, jd, g;
    if (cyc >= free_cyc) check_idle();
    cmd_valid = 1'b1;
    cmd_tiles = TW'(n);
    acc = (cyc > free_cyc) ? cyc : free_cyc;
    if (mute && n > 0) begin
      expq.push_back('{1'b0, acc + 1, 0, 1'b0});
      jd = acc + 2 + TO;
      expq.push_back('{1'b1, jd, 0, 1'b1});
      exp_tiles = 0;
      exp_err   = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) expq.push_back('{1'b0, acc + 1 + STEP * i, i, 1'b0});
      jd = acc + 1 + STEP * n;
      expq.push_back('{1'b1, jd, n, 1'b0});
      exp_tiles = n;
      exp_err   = 1'b0;
    end
    free_cyc = jd + 1;
    g = 0;
    while (cyc < acc && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("accept_cycle", cyc, acc);
    chk("accept_ready", int'(cmd_ready_o), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_tiles = TW'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    check_idle();
    rst = 1'b0;
    free_cyc = cyc;
    idle(1);

    issue(1);
    wait_free();
    // Back-to-back: valid held high through the 3-tile job.
    issue(3);
    issue(2);
    wait_free();
    issue(0);
    wait_free();

    spur_idle = 1'b1;
    idle(4);
    spur_idle  = 1'b0;
    spur_issue = 1'b1;
    issue(2);
    wait_free();
    spur_issue = 1'b0;

    // Reset while waiting on the second tile of a 3-tile job.
    issue(3);
    idle(8);
    rst = 1'b1;
    expq.delete();
    #1;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_cmd_ready", int'(cmd_ready_o), 1);
    chk("reset_tiles_done", int'(tiles_done_o), 0);
    chk("reset_start", int'(start_o), 0);
    chk("reset_job_done", int'(job_done_o), 0);
    idle(2);
    rst = 1'b0;
    free_cyc  = cyc;
    exp_tiles = 0;
    exp_err   = 1'b0;
    idle(10);
    check_idle();

`ifdef MMU_DISPATCH_TIMEOUT_EN
    mute = 1'b1;
    issue(2);
    wait_free();
    idle(2);
    check_idle();
    mute = 1'b0;
    issue(1);
    wait_free();
`endif

    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(0, 5);
      spur_issue = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) != 0) begin
        wait_free();
        spur_idle = 1'b1;
        idle($urandom_range(0, 3));
        spur_idle = 1'b0;
      end
      issue(n);
    end
    wait_free();
    spur_issue = 1'b0;
    idle(3);
    check_idle();
    chk("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
